f_pc_redirect: RTL

Fetch-stage PC register and F/D pipeline register for the five-stage MIPS core. It consumes the D-stage branch decision (branch-taken and delay-slot-annul signals from the D-stage comparator) plus the decoded next-PC operation, and redirects fetch. It squashes the delay-slot instruction for annulling branches and holds both registers under a hazard stall. It sits between the instruction memory (F) and the D-stage decoder, and is the consumer end of the comparator's `B_jump`/`Flush_check` outputs.

---
 rtl/f_pc_redirect.sv | 88 ++++++++
 1 files changed

// File: rtl/f_pc_redirect.sv
// Fetch PC register and F/D pipeline register. Redirects fetch from the D-stage
// branch/jump decision, squashes annulled delay slots and holds under stall.
module f_pc_redirect #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] F_Instr,
  input  logic [1:0]  D_NPCOp,
  input  logic        D_B_jump,
  input  logic        D_Flush_check,
  input  logic [15:0] D_Imm16,
  input  logic [25:0] D_Imm26,
  input  logic [31:0] D_RS_Data,
  output logic [31:0] F_PC,
  output logic [31:0] D_Instr,
  output logic [31:0] D_PC
);

  typedef enum logic [1:0] {
    NpcPc4    = 2'd0,
    NpcBranch = 2'd1,
    NpcJump   = 2'd2,
    NpcJr     = 2'd3
  } npc_op_e;

  typedef enum logic [1:0] {StRun, StHold, StSquash} mode_e;

  logic [31:0] f_pc_q, d_instr_q, d_pc_q;
  logic [31:0] pc4, br_target, npc;
  mode_e       mode;

  assign pc4       = f_pc_q + 32'd4;
  assign br_target = d_pc_q + 32'd4 + {{14{D_Imm16[15]}}, D_Imm16, 2'b00};

  always_comb begin
    npc = pc4;
    unique case (npc_op_e'(D_NPCOp))
      NpcPc4:    npc = pc4;
      NpcBranch: npc = D_B_jump ? br_target : pc4;
      NpcJump:   npc = {d_pc_q[31:28], D_Imm26, 2'b00};
      NpcJr:     npc = D_RS_Data;
    endcase
  end

  // Stall outranks flush: comparator inputs may be unforwarded while stalled.
  always_comb begin
    mode = StRun;
    if (stall) begin
      mode = StHold;
    end else if (D_Flush_check) begin
      mode = StSquash;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc_q    <= RESET_PC;
      d_instr_q <= NOP_INSTR;
      d_pc_q    <= RESET_PC;
    end else begin
      case (mode)
        StHold: begin
          f_pc_q    <= f_pc_q;
          d_instr_q <= d_instr_q;
          d_pc_q    <= d_pc_q;
        end
        StSquash: begin
          f_pc_q    <= npc;
          d_instr_q <= NOP_INSTR;
          d_pc_q    <= f_pc_q;
        end
        default: begin
          f_pc_q    <= npc;
          d_instr_q <= F_Instr;
          d_pc_q    <= f_pc_q;
        end
      endcase
    end
  end

  assign F_PC    = f_pc_q;
  assign D_Instr = d_instr_q;
  assign D_PC    = d_pc_q;

endmodule
